gpio_blink_monitor: RTL and testbench

Synthesizable, parametrised multi-channel GPIO activity checker for the management SoC. It generalises the single-pin "N blinks then pass" monitor used in our gpio_mgmt test flow into on-chip hardware. Per enabled channel, it counts qualified high pulses ("blinks") and declares pass when every enabled channel reaches the target count, or fail on timeout. It sits beside the mgmt GPIO/LA outputs and reports status through the logic analyzer probes or housekeeping.

---
 rtl/gpio_blink_monitor.sv | 219 +++++++++++++++++++++
 tb/tb_gpio_blink_monitor.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_blink_monitor.sv
// gpio_blink_monitor: multi-channel GPIO blink checker.
// Each channel synchronizes its pad, qualifies high pulses by width and counts
// them. A small FSM declares PASS once every masked channel reaches the target,
// or FAIL when the RUN-cycle budget runs out.

// Per-channel qualifier: synchronizer, edge detect, width filter, blink counter.
module gpio_blink_chan #(
   parameter int COUNT_W     = 8,
   parameter int MINW_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               gpio_i,
   input  logic               clr_i,
   input  logic               run_i,
   input  logic [MINW_W-1:0]  minw_i,
   output logic [COUNT_W-1:0] count_o,
   output logic               glitch_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   seen_low_q, seen_low_d;
   logic [MINW_W-1:0]      width_q, width_d;
   logic [COUNT_W-1:0]     count_q, count_d;
   logic                   glitch_q, glitch_d;

   logic                   s, rise, fall;
   logic [MINW_W-1:0]      minw_eff;

   assign s        = sync_q[SYNC_STAGES-1];
   assign rise     = s & ~prev_q;
   assign fall     = ~s & prev_q;
   assign minw_eff = (minw_i == '0) ? MINW_W'(1) : minw_i;

   // Synchronizer and previous-sample register run in every state.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
         prev_q <= s;
      end
   end

   // Qualification logic; only RUN updates state, so counts freeze elsewhere.
   always_comb begin
      seen_low_d = seen_low_q;
      width_d    = width_q;
      count_d    = count_q;
      glitch_d   = glitch_q;
      if (clr_i) begin
         seen_low_d = 1'b0;
         width_d    = '0;
         count_d    = '0;
         glitch_d   = 1'b0;
      end else if (run_i) begin
         if (!s) seen_low_d = 1'b1;
         // Width counts high cycles of the current pulse, the rise cycle is 1.
         if (rise)
            width_d = MINW_W'(1);
         else if (s && seen_low_q && (width_q != '1))
            width_d = width_q + 1'b1;
         // A pulse already in progress when RUN began is never judged.
         if (fall && seen_low_q) begin
            if (width_q >= minw_eff) begin
               if (count_q != '1) count_d = count_q + 1'b1;
            end else begin
               glitch_d = 1'b1;
            end
         end
      end
   end

   // Channel state registers.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         seen_low_q <= 1'b0;
         width_q    <= '0;
         count_q    <= '0;
         glitch_q   <= 1'b0;
      end else begin
         seen_low_q <= seen_low_d;
         width_q    <= width_d;
         count_q    <= count_d;
         glitch_q   <= glitch_d;
      end
   end

   assign count_o  = count_q;
   assign glitch_o = glitch_q;

endmodule

module gpio_blink_monitor #(
   parameter int CHANNELS    = 8,
   parameter int COUNT_W     = 8,
   parameter int TIMEOUT_W   = 24,
   parameter int MINW_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        core_clk,
   input  logic                        core_rstn,
   input  logic                        start,
   input  logic                        clear,
   input  logic [CHANNELS-1:0]         gpio_in,
   input  logic [CHANNELS-1:0]         chan_mask,
   input  logic [COUNT_W-1:0]          target_blinks,
   input  logic [TIMEOUT_W-1:0]        timeout_cycles,
   input  logic [MINW_W-1:0]           min_width,
   output logic [CHANNELS*COUNT_W-1:0] blink_count,
   output logic [CHANNELS-1:0]         chan_done,
   output logic [CHANNELS-1:0]         glitch,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic                        fail
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_ARM, ST_RUN, ST_PASS, ST_FAIL
   } state_t;

   state_t                            state_q, state_d;
   logic [CHANNELS-1:0]               mask_q;
   logic [COUNT_W-1:0]                target_q;
   logic [TIMEOUT_W-1:0]              tmo_lim_q;
   logic [MINW_W-1:0]                 minw_q;
   logic [TIMEOUT_W-1:0]              tmo_q;

   logic [CHANNELS-1:0][COUNT_W-1:0]  cnt;
   logic                              launch, chan_clr, chan_run;
   logic                              all_done, tmo_hit;

   assign launch   = (state_q == ST_IDLE) && start && !clear;
   assign chan_clr = clear || launch;
   assign chan_run = (state_q == ST_RUN);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      gpio_blink_chan #(
         .COUNT_W    (COUNT_W),
         .MINW_W     (MINW_W),
         .SYNC_STAGES(SYNC_STAGES)
      ) u_chan (
         .clk_i   (core_clk),
         .rstn_i  (core_rstn),
         .gpio_i  (gpio_in[g]),
         .clr_i   (chan_clr),
         .run_i   (chan_run),
         .minw_i  (minw_q),
         .count_o (cnt[g]),
         .glitch_o(glitch[g])
      );
      assign chan_done[g] = mask_q[g] & (cnt[g] >= target_q);
   end

   assign blink_count = cnt;
   assign all_done    = &(chan_done | ~mask_q);
   assign tmo_hit     = (tmo_lim_q != '0) && (tmo_q == tmo_lim_q - TIMEOUT_W'(1));

   // Configuration capture at launch; clear and reset drop it so outputs read 0.
   always_ff @(posedge core_clk) begin
      if (!core_rstn || clear) begin
         mask_q    <= '0;
         target_q  <= '0;
         tmo_lim_q <= '0;
         minw_q    <= '0;
      end else if (launch) begin
         mask_q    <= chan_mask;
         target_q  <= target_blinks;
         tmo_lim_q <= timeout_cycles;
         minw_q    <= min_width;
      end
   end

   // RUN-cycle counter: zeroed in ARM, advances once per RUN cycle.
   always_ff @(posedge core_clk) begin
      if (!core_rstn || clear || launch)
         tmo_q <= '0;
      else if (state_q == ST_ARM)
         tmo_q <= '0;
      else if (state_q == ST_RUN)
         tmo_q <= tmo_q + 1'b1;
   end

   // State register.
   always_ff @(posedge core_clk) begin
      if (!core_rstn) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   // Next-state logic; pass condition takes priority over timeout.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start) state_d = ST_ARM;
            ST_ARM:  state_d = ST_RUN;
            ST_RUN: begin
               if (all_done)     state_d = ST_PASS;
               else if (tmo_hit) state_d = ST_FAIL;
            end
            ST_PASS: state_d = ST_PASS;
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign busy = (state_q == ST_ARM) || (state_q == ST_RUN);
   assign done = (state_q == ST_PASS) || (state_q == ST_FAIL);
   assign pass = (state_q == ST_PASS);
   assign fail = (state_q == ST_FAIL);

endmodule

// File: tb/tb_gpio_blink_monitor.sv
// Testbench for gpio_blink_monitor: directed scenarios plus randomized pulse
// trains scored against a run-length model of the qualified blinks.
module tb_gpio_blink_monitor;

   localparam int CH = 8;
   localparam int CW = 8;
   localparam int TW = 24;
   localparam int MW = 4;
   localparam int SS = 2;
   localparam int WLEN = 160;

   logic              core_clk = 1'b0;
   logic              core_rstn;
   logic              start, clear;
   logic [CH-1:0]     gpio_in, chan_mask;
   logic [CW-1:0]     target_blinks;
   logic [TW-1:0]     timeout_cycles;
   logic [MW-1:0]     min_width;
   logic [CH*CW-1:0]  blink_count;
   logic [CH-1:0]     chan_done, glitch;
   logic              busy, done, pass, fail;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   int a0   = 0;

   logic [CH-1:0] wave [0:WLEN-1];

   gpio_blink_monitor #(
      .CHANNELS(CH), .COUNT_W(CW), .TIMEOUT_W(TW), .MINW_W(MW), .SYNC_STAGES(SS)
   ) dut (
      .core_clk(core_clk), .core_rstn(core_rstn), .start(start), .clear(clear),
      .gpio_in(gpio_in), .chan_mask(chan_mask), .target_blinks(target_blinks),
      .timeout_cycles(timeout_cycles), .min_width(min_width),
      .blink_count(blink_count), .chan_done(chan_done), .glitch(glitch),
      .busy(busy), .done(done), .pass(pass), .fail(fail)
   );

   always #5 core_clk = ~core_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [CW-1:0] cnt(input int i);
      return blink_count[i*CW +: CW];
   endfunction

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge core_clk);
         #1;
         cyc++;
      end
   endtask

   // Advance until n cycles have elapsed since the start edge.
   task automatic step_to(input int n);
      while ((cyc - a0) < n) step();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic start_run(input logic [CH-1:0] m, input int tgt, input int tmo, input int mw);
      chan_mask      = m;
      target_blinks  = CW'(tgt);
      timeout_cycles = TW'(tmo);
      min_width      = MW'(mw);
      start          = 1'b1;
      step();
      start          = 1'b0;
      a0             = cyc;
   endtask

   task automatic pulse(input int ch, input int w, input int gap);
      gpio_in[ch] = 1'b1;
      step(w);
      gpio_in[ch] = 1'b0;
      step(gap);
   endtask

   task automatic test_reset();
      core_rstn = 1'b0;
      step(3);
      nchk++; if ({busy, done, pass, fail} !== 4'b0) begin nerr++; $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, fail}); end
      nchk++; if (blink_count !== '0) begin nerr++; $display("FAIL reset_counts: got %h want 0", blink_count); end
      nchk++; if ({chan_done, glitch} !== '0) begin nerr++; $display("FAIL reset_done_glitch: got %h want 0", {chan_done, glitch}); end
      core_rstn = 1'b1;
      step(2);
   endtask

   task automatic test_single_train();
      do_clear();
      gpio_in = '0;
      start_run(8'h01, 10, 0, 2);
      nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL busy_after_start: got %b want 1", busy); end
      step(4);
      for (int k = 0; k < 9; k++) pulse(0, 4, 4);
      nchk++; if (cnt(0) !== 8'd9) begin nerr++; $display("FAIL train_nine: got %0d want 9", cnt(0)); end
      gpio_in[0] = 1'b1;
      step(4);
      gpio_in[0] = 1'b0;
      step(SS);
      nchk++; if (cnt(0) !== 8'd9) begin nerr++; $display("FAIL train_latency_early: got %0d want 9", cnt(0)); end
      step();
      nchk++; if (cnt(0) !== 8'd10) begin nerr++; $display("FAIL train_ten: got %0d want 10", cnt(0)); end
      nchk++; if ({pass, chan_done[0]} !== 2'b01) begin nerr++; $display("FAIL train_pass_early: got pass,done=%b want 01", {pass, chan_done[0]}); end
      step();
      nchk++; if ({busy, done, pass, fail} !== 4'b0110) begin nerr++; $display("FAIL train_pass: got %b want 0110", {busy, done, pass, fail}); end
   endtask

   task automatic test_timeout();
      do_clear();
      gpio_in = '0;
      start_run(8'h05, 3, 1000, 1);
      step(4);
      for (int k = 0; k < 3; k++) pulse(0, $urandom_range(1, 6), 3);
      for (int k = 0; k < 2; k++) pulse(2, $urandom_range(1, 6), 3);
      step_to(1000);
      nchk++; if ({busy, fail, pass} !== 3'b100) begin nerr++; $display("FAIL timeout_before: got busy,fail,pass=%b want 100", {busy, fail, pass}); end
      step();
      nchk++; if ({fail, pass, done} !== 3'b101) begin nerr++; $display("FAIL timeout_fail: got fail,pass,done=%b want 101", {fail, pass, done}); end
      nchk++; if (chan_done !== 8'h01) begin nerr++; $display("FAIL timeout_chan_done: got %h want 01", chan_done); end
      nchk++; if ({cnt(0), cnt(2)} !== {8'd3, 8'd2}) begin nerr++; $display("FAIL timeout_counts: got %0d,%0d want 3,2", cnt(0), cnt(2)); end
   endtask

   task automatic test_glitch();
      int w [4] = '{2, 5, 3, 6};
      do_clear();
      gpio_in = '0;
      start_run(8'h02, 10, 0, 4);
      step(4);
      for (int k = 0; k < 4; k++) pulse(1, w[k], 4);
      step(6);
      nchk++; if (cnt(1) !== 8'd2) begin nerr++; $display("FAIL glitch_count: got %0d want 2", cnt(1)); end
      nchk++; if (glitch !== 8'h02) begin nerr++; $display("FAIL glitch_flag: got %h want 02", glitch); end
      // min_width of 0 behaves as 1: single-cycle pulses count.
      do_clear();
      start_run(8'h02, 10, 0, 0);
      step(4);
      for (int k = 0; k < 3; k++) pulse(1, 1, 2);
      step(6);
      nchk++; if ({cnt(1), glitch} !== {8'd3, 8'h00}) begin nerr++; $display("FAIL minw_zero: got cnt=%0d glitch=%h want 3,00", cnt(1), glitch); end
   endtask

   task automatic test_start_high();
      do_clear();
      gpio_in = '0;
      gpio_in[3] = 1'b1;
      step(4);
      start_run(8'h08, 5, 0, 2);
      step(6);
      gpio_in[3] = 1'b0;
      step(4);
      pulse(3, 5, 4);
      step(4);
      nchk++; if (cnt(3) !== 8'd1) begin nerr++; $display("FAIL start_high_count: got %0d want 1", cnt(3)); end
      nchk++; if (glitch !== 8'h00) begin nerr++; $display("FAIL start_high_glitch: got %h want 00", glitch); end
   endtask

   // Random concurrent pulse trains; model counts runs of ones per channel.
   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         int mw, mweff, tgt, pos, np, w, gap;
         int exp_cnt [CH];
         logic [CH-1:0] exp_gl, exp_dn, m;
         mw    = $urandom_range(0, 5);
         mweff = (mw == 0) ? 1 : mw;
         tgt   = $urandom_range(1, 4);
         m     = CH'($urandom_range(0, 127)) | 8'h80;
         exp_gl = '0;
         for (int t = 0; t < WLEN; t++) wave[t] = '0;
         for (int ch = 0; ch < CH; ch++) begin
            exp_cnt[ch] = 0;
            pos = 4;
            np  = (ch == CH - 1) ? 0 : $urandom_range(0, 7);
            for (int p = 0; p < np; p++) begin
               w   = $urandom_range(1, 8);
               gap = $urandom_range(1, 5);
               if (pos + w + gap > WLEN - 8) break;
               for (int t = pos; t < pos + w; t++) wave[t][ch] = 1'b1;
               if (w >= mweff) exp_cnt[ch]++;
               else            exp_gl[ch] = 1'b1;
               pos += w + gap;
            end
         end
         for (int ch = 0; ch < CH; ch++) exp_dn[ch] = m[ch] && (exp_cnt[ch] >= tgt);
         do_clear();
         gpio_in = '0;
         step(2);
         start_run(m, tgt, 0, mw);
         for (int t = 0; t < WLEN; t++) begin
            gpio_in = wave[t];
            step();
         end
         step(4);
         for (int ch = 0; ch < CH; ch++) begin
            nchk++; if (cnt(ch) !== CW'(exp_cnt[ch])) begin nerr++; $display("FAIL rand_count it%0d ch%0d: got %0d want %0d", it, ch, cnt(ch), exp_cnt[ch]); end
         end
         nchk++; if (glitch !== exp_gl) begin nerr++; $display("FAIL rand_glitch it%0d: got %h want %h", it, glitch, exp_gl); end
         nchk++; if (chan_done !== exp_dn) begin nerr++; $display("FAIL rand_chan_done it%0d: got %h want %h", it, chan_done, exp_dn); end
         nchk++; if ({busy, pass} !== 2'b10) begin nerr++; $display("FAIL rand_state it%0d: got busy,pass=%b want 10", it, {busy, pass}); end
      end
   endtask

   task automatic test_mask_zero();
      do_clear();
      gpio_in = '0;
      start_run(8'h00, 5, 0, 1);
      step();
      nchk++; if ({busy, pass} !== 2'b10) begin nerr++; $display("FAIL mask0_run: got busy,pass=%b want 10", {busy, pass}); end
      step();
      nchk++; if ({busy, done, pass} !== 3'b011) begin nerr++; $display("FAIL mask0_pass: got %b want 011", {busy, done, pass}); end
      do_clear();
      start_run(8'hFF, 0, 0, 1);
      step(2);
      nchk++; if ({pass, chan_done} !== {1'b1, 8'hFF}) begin nerr++; $display("FAIL target0_pass: got pass=%b done=%h want 1,ff", pass, chan_done); end
   endtask

   // Second fall lands so completion is seen on the last RUN cycle (l=0)
   // or one cycle too late (l=1).
   task automatic test_pass_on_timeout();
      localparam int T = 40;
      for (int l = 0; l < 2; l++) begin
         do_clear();
         gpio_in = '0;
         start_run(8'h01, 2, T, 1);
         step_to(10); gpio_in[0] = 1'b1;
         step_to(14); gpio_in[0] = 1'b0;
         step_to(20); gpio_in[0] = 1'b1;
         step_to(T - 3 + l); gpio_in[0] = 1'b0;
         step_to(T);
         nchk++; if ({pass, fail} !== 2'b00) begin nerr++; $display("FAIL tmo_edge_before l%0d: got pass,fail=%b want 00", l, {pass, fail}); end
         step_to(T + 1);
         nchk++; if ({pass, fail} !== ((l == 0) ? 2'b10 : 2'b01)) begin nerr++; $display("FAIL tmo_edge l%0d: got pass,fail=%b want %b", l, {pass, fail}, (l == 0) ? 2'b10 : 2'b01); end
         nchk++; if (cnt(0) !== 8'd2) begin nerr++; $display("FAIL tmo_edge_count l%0d: got %0d want 2", l, cnt(0)); end
      end
   endtask

   task automatic test_saturation();
      do_clear();
      gpio_in = '0;
      start_run(8'h01, 255, 0, 1);
      step(4);
      repeat (260) pulse(1, 2, 2);
      step(4);
      nchk++; if (cnt(1) !== 8'd255) begin nerr++; $display("FAIL sat_count: got %0d want 255", cnt(1)); end
      nchk++; if ({cnt(0), busy, pass, chan_done} !== {8'd0, 1'b1, 1'b0, 8'h00}) begin nerr++; $display("FAIL sat_state: got cnt0=%0d busy=%b pass=%b done=%h", cnt(0), busy, pass, chan_done); end
   endtask

   task automatic test_control();
      // clear mid-RUN
      do_clear();
      gpio_in = '0;
      start_run(8'h01, 3, 0, 3);
      step(4);
      pulse(0, 4, 3);
      pulse(1, 1, 3);
      step(4);
      nchk++; if ({cnt(0), glitch} !== {8'd1, 8'h02}) begin nerr++; $display("FAIL ctrl_pre_clear: got cnt0=%0d glitch=%h want 1,02", cnt(0), glitch); end
      clear = 1'b1;
      step();
      clear = 1'b0;
      nchk++; if ({busy, done, pass, fail, chan_done, glitch, blink_count} !== '0) begin nerr++; $display("FAIL ctrl_clear: got flags=%b cnt=%h glitch=%h", {busy, done, pass, fail}, blink_count, glitch); end
      // clear beats start
      start = 1'b1; clear = 1'b1;
      step();
      start = 1'b0; clear = 1'b0;
      step();
      nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL ctrl_clear_prio: got busy=%b want 0", busy); end
      // reset mid-RUN
      start_run(8'h01, 3, 0, 1);
      step(4);
      pulse(0, 3, 3);
      step(4);
      core_rstn = 1'b0;
      step();
      nchk++; if ({busy, done, pass, fail, chan_done, glitch, blink_count} !== '0) begin nerr++; $display("FAIL ctrl_reset: got flags=%b cnt=%h", {busy, done, pass, fail}, blink_count); end
      core_rstn = 1'b1;
      step();
      // start while in PASS
      start_run(8'h00, 1, 0, 1);
      step(2);
      nchk++; if (pass !== 1'b1) begin nerr++; $display("FAIL ctrl_pass_reach: got %b want 1", pass); end
      start_run(8'hFF, 9, 0, 1);
      step(3);
      nchk++; if ({busy, done, pass, chan_done} !== {3'b011, 8'h00}) begin nerr++; $display("FAIL ctrl_start_in_pass: got %b done=%h want 011,00", {busy, done, pass}, chan_done); end
   endtask

   initial begin
      core_rstn = 1'b0; start = 1'b0; clear = 1'b0; gpio_in = '0;
      chan_mask = '0; target_blinks = '0; timeout_cycles = '0; min_width = '0;
      test_reset();
      test_single_train();
      test_timeout();
      test_glitch();
      test_start_high();
      test_random();
      test_mask_zero();
      test_pass_on_timeout();
      test_saturation();
      test_control();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
      $finish;
   end

endmodule
